// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Shared definitions for the branch resolve unit:
//   - kind_e      : request kind encoding (branch / JAL / JALR / pass-through)
//   - F3_*        : branch condition codes carried in funct3
//   - BHT_RST_VAL : predictor counter value after reset (weakly not-taken)
//   - sat_step()  : 2-bit saturating counter step
// -----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'b00,
        KIND_JAL    = 2'b01,
        KIND_JALR   = 2'b10,
        KIND_NONE   = 2'b11
    } kind_e;

    localparam logic [2:0] F3_EQ  = 3'b000;
    localparam logic [2:0] F3_NE  = 3'b001;
    localparam logic [2:0] F3_LT  = 3'b100;
    localparam logic [2:0] F3_GE  = 3'b101;
    localparam logic [2:0] F3_LTU = 3'b110;
    localparam logic [2:0] F3_GEU = 3'b111;

    localparam logic [1:0] BHT_RST_VAL = 2'b01;

    // Move a 2-bit predictor counter one step towards taken/not-taken,
    // holding at the 0 and 3 bounds.
    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
        logic [1:0] res;
        res = ctr;
        if (up) begin
            if (ctr != 2'b11) res = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_branch_cond.sv
// -----------------------------------------------------------------------------
// branch_cond
// Combinational branch condition evaluator.
// Ports:
//   i_funct3  : condition code
//   i_rs1/2   : XLEN-bit operands
//   o_taken   : condition holds (0 for unsupported codes)
//   o_illegal : condition code 010/011 is not a valid branch
// -----------------------------------------------------------------------------
module branch_cond
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_taken,
    output logic            o_illegal
);

    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_EQ:   o_taken = (i_rs1 == i_rs2);
            F3_NE:   o_taken = (i_rs1 != i_rs2);
            F3_LT:   o_taken = ($signed(i_rs1) <  $signed(i_rs2));
            F3_GE:   o_taken = ($signed(i_rs1) >= $signed(i_rs2));
            F3_LTU:  o_taken = (i_rs1 <  i_rs2);
            F3_GEU:  o_taken = (i_rs1 >= i_rs2);
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Resolves branch / JAL / JALR requests one cycle after acceptance, reports
// direction, target, redirect PC and misprediction, and trains a table of
// 2-bit saturating predictor counters indexed by PC.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   in_valid/in_ready       : request handshake
//   in_kind, in_funct3      : request kind and branch condition
//   in_pc/rs1/rs2/imm       : PC, operands, sign-extended immediate
//   in_pred_taken/target    : front-end prediction to verify
//   flush                   : drop held result, block acceptance
//   lookup_pc/lookup_taken  : combinational predictor lookup
//   out_valid/out_ready     : result handshake
//   out_taken, out_mispredict, out_illegal, out_target, out_redirect_pc
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_kind,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_target,
    input  logic            flush,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_redirect_pc
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    kind_e            w_kind;
    logic             w_accept;
    logic             w_cond_taken;
    logic             w_cond_illegal;
    logic             w_taken;
    logic             w_illegal;
    logic             w_mispredict;
    logic [XLEN-1:0]  w_jalr_sum;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_seq_pc;
    logic [XLEN-1:0]  w_redirect;
    logic [IDX_W-1:0] w_upd_idx;
    logic [IDX_W-1:0] w_lkp_idx;
    logic             w_bht_we;
    logic [BHT_DEPTH-1:0] w_bht_msb;
    logic             w_unused;

    logic             r_out_valid;
    logic             r_out_taken;
    logic             r_out_mispredict;
    logic             r_out_illegal;
    logic [XLEN-1:0]  r_out_target;
    logic [XLEN-1:0]  r_out_redirect;

    assign w_kind = kind_e'(in_kind);

    branch_cond #(.XLEN(XLEN)) u_cond (
        .i_funct3  (in_funct3),
        .i_rs1     (in_rs1),
        .i_rs2     (in_rs2),
        .o_taken   (w_cond_taken),
        .o_illegal (w_cond_illegal)
    );

    assign w_jalr_sum = in_rs1 + in_imm;
    assign w_seq_pc   = in_pc + {{(XLEN-3){1'b0}}, 3'd4};

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        w_target  = in_pc + in_imm;
        case (w_kind)
            KIND_BRANCH: begin
                w_taken   = w_cond_taken;
                w_illegal = w_cond_illegal;
            end
            KIND_JAL:  w_taken = 1'b1;
            KIND_JALR: begin
                w_taken  = 1'b1;
                w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
    end

    assign w_redirect   = w_taken ? w_target : w_seq_pc;
    assign w_mispredict = (w_taken != in_pred_taken) |
                          (w_taken & (w_target != in_pred_target));

    // Holding reset low also holds off the producer.
    assign in_ready = rst_n & ~flush & (~r_out_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid      <= 1'b0;
            r_out_taken      <= 1'b0;
            r_out_mispredict <= 1'b0;
            r_out_illegal    <= 1'b0;
            r_out_target     <= '0;
            r_out_redirect   <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid      <= 1'b1;
            r_out_taken      <= w_taken;
            r_out_mispredict <= w_mispredict;
            r_out_illegal    <= w_illegal;
            r_out_target     <= w_target;
            r_out_redirect   <= w_redirect;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid       = r_out_valid;
    assign out_taken       = r_out_taken;
    assign out_mispredict  = r_out_mispredict;
    assign out_illegal     = r_out_illegal;
    assign out_target      = r_out_target;
    assign out_redirect_pc = r_out_redirect;

    // Predictor table: only legal conditional branches train it.
    assign w_upd_idx = in_pc[IDX_W+1:2];
    assign w_lkp_idx = lookup_pc[IDX_W+1:2];
    assign w_bht_we  = w_accept & (w_kind == KIND_BRANCH) & ~w_cond_illegal;

    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
            logic [1:0] r_ctr;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_ctr <= BHT_RST_VAL;
                end else if (w_bht_we && (w_upd_idx == IDX_W'(gi))) begin
                    r_ctr <= sat_step(r_ctr, w_cond_taken);
                end
            end
            assign w_bht_msb[gi] = r_ctr[1];
        end
    endgenerate

    // Reads the registered counter, so a same-cycle update is not visible yet.
    assign lookup_taken = w_bht_msb[w_lkp_idx];

    assign w_unused = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0], w_jalr_sum[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed scenarios with literal expectations, then randomized traffic.
// A behavioural model (expected result record + counter array) is compared
// against the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_kind;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_pc, in_rs1, in_rs2, in_imm;
    logic             in_pred_taken;
    logic [XLEN-1:0]  in_pred_target;
    logic             flush;
    logic [XLEN-1:0]  lookup_pc;
    logic             lookup_taken;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken, out_mispredict, out_illegal;
    logic [XLEN-1:0]  out_target, out_redirect_pc;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_kind         (in_kind),
        .in_funct3       (in_funct3),
        .in_pc           (in_pc),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_imm          (in_imm),
        .in_pred_taken   (in_pred_taken),
        .in_pred_target  (in_pred_target),
        .flush           (flush),
        .lookup_pc       (lookup_pc),
        .lookup_taken    (lookup_taken),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_taken       (out_taken),
        .out_mispredict  (out_mispredict),
        .out_illegal     (out_illegal),
        .out_target      (out_target),
        .out_redirect_pc (out_redirect_pc)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          mon_on   = 1'b0;
    bit          m_valid  = 1'b0;
    bit          m_zero   = 1'b1;
    bit          m_taken  = 1'b0;
    bit          m_mis    = 1'b0;
    bit          m_ill    = 1'b0;
    logic [1:0]  m_kind   = 2'd0;
    logic [31:0] m_target = '0;
    logic [31:0] m_redir  = '0;
    int          m_bht [DEPTH];

    bit          e_rdy, e_tk, e_ill, e_mis;
    logic [31:0] e_tg, e_rd;
    int          e_idx;

    function automatic void resolve(input logic [1:0] k, input logic [2:0] f3,
                                    input logic [31:0] pc, input logic [31:0] rs1,
                                    input logic [31:0] rs2, input logic [31:0] imm,
                                    input bit pt, input logic [31:0] ptg,
                                    output bit tk, output bit ill, output logic [31:0] tg,
                                    output logic [31:0] rd, output bit mis);
        tk  = 1'b0;
        ill = 1'b0;
        if (k == 2'd2) tg = (rs1 + imm) & 32'hFFFF_FFFE;
        else           tg = pc + imm;
        if (k == 2'd0) begin
            if      (f3 == 3'd0) tk = (rs1 == rs2);
            else if (f3 == 3'd1) tk = (rs1 != rs2);
            else if (f3 == 3'd4) tk = ($signed(rs1) <  $signed(rs2));
            else if (f3 == 3'd5) tk = ($signed(rs1) >= $signed(rs2));
            else if (f3 == 3'd6) tk = (rs1 <  rs2);
            else if (f3 == 3'd7) tk = (rs1 >= rs2);
            else                 ill = 1'b1;
        end else if (k != 2'd3) begin
            tk = 1'b1;
        end
        rd  = tk ? tg : pc + 32'd4;
        mis = (tk != pt) || (tk && (tg != ptg));
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            e_rdy = rst_n && !flush && (!m_valid || out_ready);
            e_idx = int'((lookup_pc >> 2) & 32'(DEPTH - 1));
            check("in_ready", in_ready, e_rdy);
            check("lookup_taken", lookup_taken, (m_bht[e_idx] >= 2));
            check("out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("out_taken", out_taken, m_taken);
                check("out_mispredict", out_mispredict, m_mis);
                check("out_illegal", out_illegal, m_ill);
                check("out_redirect_pc", out_redirect_pc, m_redir);
                if (m_kind != 2'd3) check("out_target", out_target, m_target);
            end else if (m_zero) begin
                check("zero_outputs",
                      {out_taken, out_mispredict, out_illegal, out_target, out_redirect_pc}, 0);
            end
            // advance the model by the edge that follows
            if (!rst_n) begin
                m_valid = 1'b0;
                m_zero  = 1'b1;
                m_taken = 1'b0; m_mis = 1'b0; m_ill = 1'b0;
                m_target = '0;  m_redir = '0;
                for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
            end else if (flush) begin
                m_valid = 1'b0;
            end else if (in_valid && e_rdy) begin
                resolve(in_kind, in_funct3, in_pc, in_rs1, in_rs2, in_imm,
                        in_pred_taken, in_pred_target, e_tk, e_ill, e_tg, e_rd, e_mis);
                m_valid = 1'b1; m_zero = 1'b0;
                m_taken = e_tk; m_ill = e_ill; m_mis = e_mis;
                m_target = e_tg; m_redir = e_rd; m_kind = in_kind;
                if (in_kind == 2'd0 && !e_ill) begin
                    e_idx = int'((in_pc >> 2) & 32'(DEPTH - 1));
                    if (e_tk) m_bht[e_idx] = (m_bht[e_idx] < 3) ? m_bht[e_idx] + 1 : 3;
                    else      m_bht[e_idx] = (m_bht[e_idx] > 0) ? m_bht[e_idx] - 1 : 0;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic send(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptg);
        in_valid = 1'b1; in_kind = k; in_funct3 = f3; in_pc = pc;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_pred_taken = pt; in_pred_target = ptg;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; lookup_pc = '0;
        send(2'd0, 3'd0, 0, 0, 0, 0, 1'b0, 0);
        in_valid = 1'b0;
        @(posedge clk);
        mon_on = 1'b1;
        #1;
        cyc(); cyc();
        settle();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_target", out_target, 0);

        cyc(); rst_n = 1'b1; lookup_pc = 32'h100;
        settle();
        check("bht_init_weak_nt", lookup_taken, 0);

        // BEQ taken, predicted not-taken
        cyc(); send(2'd0, 3'd0, 32'h100, 5, 5, 32'h20, 1'b0, 0);
        cyc(); in_valid = 1'b0; settle();
        check("beq_taken", out_taken, 1);
        check("beq_target", out_target, 32'h120);
        check("beq_mispredict", out_mispredict, 1);
        check("beq_counter", lookup_taken, 1);

        // signed vs unsigned less-than, back to back
        cyc(); send(2'd0, 3'd4, 32'h208, 32'hFFFF_FFFF, 1, 32'h10, 1'b0, 0);
        cyc(); send(2'd0, 3'd6, 32'h208, 32'hFFFF_FFFF, 1, 32'h10, 1'b0, 0);
        settle();
        check("blt_taken", out_taken, 1);
        cyc(); in_valid = 1'b0; settle();
        check("bltu_taken", out_taken, 0);
        check("bltu_redirect", out_redirect_pc, 32'h20C);

        // JALR clears bit 0
        cyc(); send(2'd2, 3'd0, 32'h300, 32'h1001, 0, 2, 1'b1, 32'h1002);
        cyc(); in_valid = 1'b0; settle();
        check("jalr_target", out_target, 32'h1002);
        check("jalr_mispredict", out_mispredict, 0);

        // backpressure then flush
        cyc(); send(2'd0, 3'd1, 32'h84, 1, 2, 32'h40, 1'b1, 32'hC4);
        lookup_pc = 32'h84;
        cyc(); send(2'd0, 3'd0, 32'h84, 1, 2, 32'h40, 1'b0, 0); out_ready = 1'b0;
        settle();
        check("bp_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        check("bp_target", out_target, 32'hC4);
        cyc(); settle();
        check("bp_hold_target", out_target, 32'hC4);
        check("bp_hold_in_ready", in_ready, 0);
        cyc(); flush = 1'b1; settle();
        check("bp_flush_in_ready", in_ready, 0);
        cyc(); flush = 1'b0; in_valid = 1'b0; settle();
        check("bp_flushed_valid", out_valid, 0);
        check("bp_counter", lookup_taken, 1);
        out_ready = 1'b1;

        // saturation at pc 0x40, then not-taken, then illegal code
        lookup_pc = 32'h40;
        for (int i = 0; i < 4; i++) begin
            cyc(); send(2'd0, 3'd0, 32'h40, 7, 7, 8, 1'b1, 32'h48);
        end
        cyc(); in_valid = 1'b0; settle();
        check("sat_lookup", lookup_taken, 1);
        cyc(); send(2'd0, 3'd1, 32'h40, 7, 7, 8, 1'b0, 0);
        cyc(); send(2'd0, 3'd2, 32'h40, 7, 7, 8, 1'b0, 0);
        cyc(); in_valid = 1'b0; settle();
        check("ill_flag", out_illegal, 1);
        check("ill_taken", out_taken, 0);
        check("ill_counter", lookup_taken, 1);

        // wraparound at top of address space
        cyc(); send(2'd1, 3'd0, 32'hFFFF_FFFC, 0, 0, 8, 1'b1, 4);
        cyc(); send(2'd0, 3'd0, 32'hFFFF_FFFC, 1, 2, 8, 1'b0, 0);
        settle();
        check("jal_wrap_target", out_target, 32'h4);
        cyc(); in_valid = 1'b0; settle();
        check("beq_wrap_redirect", out_redirect_pc, 32'h0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc();
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_kind   = 2'($urandom_range(0, 3));
            in_funct3 = 3'($urandom_range(0, 7));
            in_pc     = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h3FC);
            in_rs1    = $urandom;
            case ($urandom_range(0, 2))
                0:       in_rs2 = in_rs1;
                1:       in_rs2 = in_rs1 ^ 32'h8000_0000;
                default: in_rs2 = $urandom;
            endcase
            in_imm = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFC) : (32'hFFFF_F000 | $urandom);
            in_pred_taken  = ($urandom_range(0, 1) != 0);
            in_pred_target = ($urandom_range(0, 1) != 0) ? in_pc + in_imm : $urandom;
            lookup_pc      = ($urandom_range(0, 1) != 0) ? in_pc : ($urandom & 32'h3FC);
        end
        cyc(); in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
        cyc(); cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
